// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Constants and helpers shared by the NTT bit-reversal reorder slice.
//   N_POINTS   : coefficients per frame
//   ADDR_WIDTH : log2(N_POINTS), width of frame index / bank address
//   bitrev()   : mirror an ADDR_WIDTH-bit index (bit 0 <-> bit ADDR_WIDTH-1, ...)
package ntt_pkg;

    localparam int N_POINTS   = 16;
    localparam int ADDR_WIDTH = 4;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] rev;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev[i] = addr[ADDR_WIDTH-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/ntt_reorder_bank.sv
// ntt_reorder_bank
//   One n_points x data_width flop bank: synchronous write, combinational read.
//   Contents are deliberately not reset; the owner tracks validity separately.
// Ports
//   clk      : clock
//   wr_en    : write wr_data at wr_addr on the rising edge
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data at rd_addr
module ntt_reorder_bank
    import ntt_pkg::*;
#(
    parameter int data_width = 64,
    parameter int n_points   = N_POINTS,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [n_points];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder
//   Takes frames arriving serially in bit-reversed order from the SDF NTT
//   pipeline and streams them out in natural order. Two banks ping-pong so
//   one frame can be written while the previous one is read out, giving
//   1 sample/clk sustained with no gap between frames.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous discard of partial and buffered frames (keeps overflow)
//   in_valid   : in_data carries a coefficient
//   in_ready   : a coefficient can be accepted this cycle
//   in_data    : coefficient, bit-reversed frame order
//   out_valid  : out_data valid
//   out_ready  : downstream accepts out_data
//   out_data   : coefficient, natural order
//   out_last   : marks the final coefficient of a frame
//   overflow   : sticky, a sample was offered while in_ready was low (cleared by rst only)
module ntt_bitrev_reorder
    import ntt_pkg::*;
#(
    parameter int data_width = 64,
    parameter int n_points   = N_POINTS,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow
);

    localparam logic [addr_width-1:0] LAST_IDX = addr_width'(n_points - 1);

    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [addr_width-1:0] wr_cnt;
    logic [addr_width-1:0] rd_cnt;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [addr_width-1:0] wr_addr;
    logic [data_width-1:0] bank_rd_data [2];

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid & (rd_cnt == LAST_IDX);
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    // Scatter on write: the k-th arrival belongs at natural index bitrev(k),
    // so the read side can simply walk addresses 0..n_points-1.
    assign wr_addr   = bitrev(wr_cnt);
    assign out_data  = bank_rd_data[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_reorder_bank #(
            .data_width (data_width),
            .n_points   (n_points),
            .addr_width (addr_width)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire & ~flush & (wr_bank == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (in_data),
            .rd_addr (rd_cnt),
            .rd_data (bank_rd_data[b])
        );
    end

    // Counters wrap to zero naturally on the last index. A frame completing
    // on the write side and one draining on the read side in the same cycle
    // always touch different full bits, so both updates are safe together.
    // flush wins over any handshake but leaves the sticky overflow alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                full    <= '0;
                wr_bank <= 1'b0;
                rd_bank <= 1'b0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
            end else begin
                if (wr_fire) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                    end
                end
                if (rd_fire) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// tb_ntt_bitrev_reorder
//   Self-checking bench for ntt_bitrev_reorder. Expected streams are derived
//   from the arrival order: natural output j of a frame is the arrival whose
//   index, bit-mirrored, equals j.
module tb_ntt_bitrev_reorder;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    ntt_bitrev_reorder #(.data_width(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Mirror a 4-bit frame index with plain masks and shifts.
    function automatic int tb_bitrev(input int i);
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        #10;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int seq [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int c = 0; c <= 32; c++) begin
            if (c < 16) applyStimulus(1'b1, DW'(seq[c]), 1'b1);
            else        applyStimulus(1'b0, '0, 1'b1);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t1_in_ready c=%0d: got %b want 1", c, in_ready); end
            checks++; if (out_valid !== (c >= 16 && c < 32)) begin failures++; $display("[TB] FAIL t1_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 16 && c < 32)); end
            if (c >= 16 && c < 32) begin
                checks++; if (out_data !== DW'(c - 16)) begin failures++; $display("[TB] FAIL t1_out_data c=%0d: got %0d want %0d", c, out_data, c - 16); end
                checks++; if (out_last !== (c == 31)) begin failures++; $display("[TB] FAIL t1_out_last c=%0d: got %b want %b", c, out_last, (c == 31)); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] din  [48];
        logic [DW-1:0] dexp [48];
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                din[f*16+i] = {$urandom, 32'(f * 256 + tb_bitrev(i))};
            end
            for (int j = 0; j < 16; j++) begin
                dexp[f*16+j] = din[f*16+tb_bitrev(j)];
            end
        end
        for (int c = 0; c <= 64; c++) begin
            if (c < 48) applyStimulus(1'b1, din[c], 1'b1);
            else        applyStimulus(1'b0, '0, 1'b1);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t2_in_ready c=%0d: got %b want 1", c, in_ready); end
            checks++; if (out_valid !== (c >= 16 && c < 64)) begin failures++; $display("[TB] FAIL t2_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 16 && c < 64)); end
            if (c >= 16 && c < 64) begin
                checks++; if (out_data !== dexp[c-16]) begin failures++; $display("[TB] FAIL t2_out_data c=%0d: got %h want %h", c, out_data, dexp[c-16]); end
                checks++; if (out_last !== ((c - 16) % 16 == 15)) begin failures++; $display("[TB] FAIL t2_out_last c=%0d: got %b want %b", c, out_last, ((c - 16) % 16 == 15)); end
            end
            tick();
        end
    endtask

    task automatic test_stall_overflow();
        logic [DW-1:0] din  [32];
        logic [DW-1:0] dexp [32];
        logic [DW-1:0] dropped;
        dropped = 64'hDEAD_BEEF_0000_0000 | DW'($urandom);
        for (int i = 0; i < 32; i++) din[i] = {$urandom, $urandom};
        for (int j = 0; j < 32; j++) dexp[j] = din[(j / 16) * 16 + tb_bitrev(j % 16)];
        for (int c = 0; c < 32; c++) begin
            applyStimulus(1'b1, din[c], 1'b0);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t3_in_ready c=%0d: got %b want 1", c, in_ready); end
            checks++; if (out_valid !== (c >= 16)) begin failures++; $display("[TB] FAIL t3_fill_valid c=%0d: got %b want %b", c, out_valid, (c >= 16)); end
            tick();
        end
        applyStimulus(1'b1, dropped, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL t3_full_in_ready: got %b want 0", in_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL t3_overflow_before: got %b want 0", overflow); end
        checks++; if (out_data !== dexp[0]) begin failures++; $display("[TB] FAIL t3_stalled_data: got %h want %h", out_data, dexp[0]); end
        tick();
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL t3_overflow k=%0d: got %b want 1", k, overflow); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t3_out_valid k=%0d: got %b want 1", k, out_valid); end
            checks++; if (out_data !== dexp[k]) begin failures++; $display("[TB] FAIL t3_out_data k=%0d: got %h want %h", k, out_data, dexp[k]); end
            checks++; if (out_last !== (k % 16 == 15)) begin failures++; $display("[TB] FAIL t3_out_last k=%0d: got %b want %b", k, out_last, (k % 16 == 15)); end
            checks++; if (in_ready !== (k >= 16)) begin failures++; $display("[TB] FAIL t3_drain_ready k=%0d: got %b want %b", k, in_ready, (k >= 16)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t3_empty_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stall_toggle();
        logic [DW-1:0] din  [16];
        logic [DW-1:0] dexp [16];
        int idx;
        logic rdy;
        for (int i = 0; i < 16; i++) din[i] = {$urandom, $urandom};
        for (int j = 0; j < 16; j++) dexp[j] = din[tb_bitrev(j)];
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, din[c], 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t4_fill_valid c=%0d: got %b want 0", c, out_valid); end
            tick();
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            rdy = (c % 2 == 0);
            applyStimulus(1'b0, '0, rdy);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t4_out_valid c=%0d: got %b want 1", c, out_valid); end
            checks++; if (out_data !== dexp[idx]) begin failures++; $display("[TB] FAIL t4_out_data c=%0d: got %h want %h", c, out_data, dexp[idx]); end
            checks++; if (out_last !== (idx == 15)) begin failures++; $display("[TB] FAIL t4_out_last c=%0d: got %b want %b", c, out_last, (idx == 15)); end
            checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL t4_overflow_sticky c=%0d: got %b want 1", c, overflow); end
            tick();
            if (rdy) idx++;
        end
        applyStimulus(1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t4_empty_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] da   [16];
        logic [DW-1:0] db   [16];
        logic [DW-1:0] dc   [16];
        logic [DW-1:0] dexp [16];
        for (int i = 0; i < 16; i++) begin
            da[i] = {$urandom, $urandom};
            db[i] = {$urandom, $urandom};
            dc[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < 31; c++) begin
            applyStimulus(1'b1, (c < 16) ? da[c] : db[c-16], 1'b0);
            tick();
        end
        applyStimulus(1'b1, db[15], 1'b1);
        flush = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_pre_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t6_pre_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== da[tb_bitrev(0)]) begin failures++; $display("[TB] FAIL t6_pre_out_data: got %h want %h", out_data, da[tb_bitrev(0)]); end
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t6_post_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL t6_post_out_last: got %b want 0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_post_in_ready: got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL t6_overflow_kept: got %b want 1", overflow); end
        for (int j = 0; j < 16; j++) dexp[j] = dc[tb_bitrev(j)];
        for (int c = 0; c <= 32; c++) begin
            if (c < 16) applyStimulus(1'b1, dc[c], 1'b1);
            else        applyStimulus(1'b0, '0, 1'b1);
            checks++; if (out_valid !== (c >= 16 && c < 32)) begin failures++; $display("[TB] FAIL t6_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 16 && c < 32)); end
            if (c >= 16 && c < 32) begin
                checks++; if (out_data !== dexp[c-16]) begin failures++; $display("[TB] FAIL t6_out_data c=%0d: got %h want %h", c, out_data, dexp[c-16]); end
                checks++; if (out_last !== (c == 31)) begin failures++; $display("[TB] FAIL t6_out_last c=%0d: got %b want %b", c, out_last, (c == 31)); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] dd   [16];
        logic [DW-1:0] df   [16];
        logic [DW-1:0] dexp [16];
        for (int i = 0; i < 16; i++) begin
            dd[i] = {$urandom, $urandom};
            df[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < 23; c++) begin
            applyStimulus(1'b1, (c < 16) ? dd[c] : DW'($urandom), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t5_pre_out_valid: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t5_async_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL t5_async_out_last: got %b want 0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t5_async_in_ready: got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL t5_async_overflow: got %b want 0", overflow); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        for (int j = 0; j < 16; j++) dexp[j] = df[tb_bitrev(j)];
        for (int c = 0; c <= 32; c++) begin
            if (c < 16) applyStimulus(1'b1, df[c], 1'b1);
            else        applyStimulus(1'b0, '0, 1'b1);
            checks++; if (out_valid !== (c >= 16 && c < 32)) begin failures++; $display("[TB] FAIL t5_out_valid c=%0d: got %b want %b", c, out_valid, (c >= 16 && c < 32)); end
            if (c >= 16 && c < 32) begin
                checks++; if (out_data !== dexp[c-16]) begin failures++; $display("[TB] FAIL t5_out_data c=%0d: got %h want %h", c, out_data, dexp[c-16]); end
                checks++; if (out_last !== (c == 31)) begin failures++; $display("[TB] FAIL t5_out_last c=%0d: got %b want %b", c, out_last, (c == 31)); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall_overflow();
        test_stall_toggle();
        test_flush();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
